// File: rtl/sprite_pkg.sv
// Shared constants and register bundle for the sprite register block.
package sprite_pkg;

    localparam int SPRITE_STRIDE   = 32;
    localparam int OFF_X           = 16;
    localparam int OFF_Y           = 17;
    localparam int OFF_CTRL        = 18;

    localparam int KBD_OFF_DATA    = 0;
    localparam int KBD_OFF_STATUS  = 1;
    localparam int KBD_OFF_COLLIDE = 2;

    localparam int CTRL_EN         = 0;

    localparam int MAX_ROWS        = 16;
    localparam int MAX_W           = 16;

    typedef struct packed {
        logic [MAX_ROWS-1:0][MAX_W-1:0] rows;
        logic [15:0]                    x;
        logic [15:0]                    y;
        logic [15:0]                    ctrl;
    } sprite_regs_t;

    // Half-open interval [a, a+size) intersects [b, b+size).
    function automatic logic span_overlap(
        input logic [10:0] a,
        input logic [10:0] b,
        input logic [10:0] size
    );
        return (a < b + size) && (b < a + size);
    endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Synchronous scan-code FIFO with sticky overflow flag.
module kbd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    input  logic         clr_ovf,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full,
    output logic         overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_pop;
    logic         do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop on a full FIFO frees the slot the simultaneous push needs.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            overflow <= (push && !do_push) || (overflow && !clr_ovf);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/sprite_regfile.sv
// Sprite shadow/active register file with vsync commit and PS/2 FIFO.
// Optional collision detection is built when SPRITE_COLLISION_EN is defined.
module sprite_regfile
    import sprite_pkg::*;
#(
    parameter int               N_SPRITES = 2,
    parameter int               BMP_H     = 16,
    parameter int               BMP_W     = 16,
    parameter int               ADDR_W    = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'h1C0,
    parameter int               KBD_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [ADDR_W-1:0]                address,
    input  logic [15:0]                      wr_data,
    input  logic                             memwt,
    input  logic                             memrd,
    output logic [15:0]                      rd_data,
    output logic                             hit,
    output logic                             ackx,
    input  logic                             vsync_irq,
    input  logic                             kbd_valid,
    input  logic [7:0]                       kbd_code,
    output logic                             kbd_irq,
    output logic [N_SPRITES*BMP_H*BMP_W-1:0] sprite_bitmap,
    output logic [N_SPRITES*10-1:0]          sprite_x,
    output logic [N_SPRITES*10-1:0]          sprite_y,
    output logic [N_SPRITES-1:0]             sprite_en
);

    localparam int                IDX_W    = ADDR_W - 5;
    localparam logic [ADDR_W-1:0] SPAN     = ADDR_W'(N_SPRITES * SPRITE_STRIDE);
    localparam logic [ADDR_W-1:0] KBD_ADDR = BASE_ADDR + SPAN;
    localparam logic [15:0]       ROW_MASK = 16'((32'd1 << BMP_W) - 32'd1);

    logic [ADDR_W-1:0] rel;
    logic [IDX_W-1:0]  idx;
    logic [4:0]        off;
    logic              spr_hit;
    logic              sel_data;
    logic              sel_stat;
    logic              sel_coll;

    assign rel      = address - BASE_ADDR;
    assign idx      = rel[ADDR_W-1:5];
    assign off      = rel[4:0];
    assign spr_hit  = (address >= BASE_ADDR) && (rel < SPAN);
    assign sel_data = (address == KBD_ADDR + ADDR_W'(KBD_OFF_DATA));
    assign sel_stat = (address == KBD_ADDR + ADDR_W'(KBD_OFF_STATUS));
    assign sel_coll = (address == KBD_ADDR + ADDR_W'(KBD_OFF_COLLIDE));
    assign hit      = spr_hit || sel_data || sel_stat || sel_coll;
    assign ackx     = sel_data;

    sprite_regs_t     shadow [N_SPRITES];
    logic [BMP_W-1:0] act_rows [N_SPRITES][BMP_H];
    logic [9:0]       act_x [N_SPRITES];
    logic [9:0]       act_y [N_SPRITES];
    logic [N_SPRITES-1:0] act_en;
    logic             vs_q;
    logic             commit;

    assign commit = vsync_irq && !vs_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SPRITES; i++) shadow[i] <= '0;
        end else if (memwt && spr_hit) begin
            for (int i = 0; i < N_SPRITES; i++) begin
                if (idx == IDX_W'(i)) begin
                    if (off < 5'(BMP_H))
                        shadow[i].rows[off[3:0]] <= wr_data & ROW_MASK;
                    else if (off == 5'(OFF_X))
                        shadow[i].x <= wr_data;
                    else if (off == 5'(OFF_Y))
                        shadow[i].y <= wr_data;
                    else if (off == 5'(OFF_CTRL))
                        shadow[i].ctrl <= wr_data;
                end
            end
        end
    end

    // Active copies read the pre-edge shadow, so a coincident write lands next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q   <= 1'b0;
            act_en <= '0;
            for (int i = 0; i < N_SPRITES; i++) begin
                act_x[i] <= '0;
                act_y[i] <= '0;
                for (int r = 0; r < BMP_H; r++) act_rows[i][r] <= '0;
            end
        end else begin
            vs_q <= vsync_irq;
            if (commit) begin
                for (int i = 0; i < N_SPRITES; i++) begin
                    act_x[i]  <= shadow[i].x[9:0];
                    act_y[i]  <= shadow[i].y[9:0];
                    act_en[i] <= shadow[i].ctrl[CTRL_EN];
                    for (int r = 0; r < BMP_H; r++)
                        act_rows[i][r] <= shadow[i].rows[r][BMP_W-1:0];
                end
            end
        end
    end

    always_comb begin
        sprite_bitmap = '0;
        sprite_x      = '0;
        sprite_y      = '0;
        for (int i = 0; i < N_SPRITES; i++) begin
            sprite_x[i*10 +: 10] = act_x[i];
            sprite_y[i*10 +: 10] = act_y[i];
            for (int r = 0; r < BMP_H; r++)
                sprite_bitmap[((i*BMP_H+r)*BMP_W) +: BMP_W] = act_rows[i][r];
        end
    end

    assign sprite_en = act_en;

    logic [7:0] fifo_dout;
    logic       fifo_empty;
    logic       fifo_full;
    logic       fifo_ovf;

    kbd_fifo #(
        .DEPTH (KBD_DEPTH),
        .W     (8)
    ) u_kbd_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (kbd_valid),
        .din      (kbd_code),
        .pop      (memrd && sel_data),
        .clr_ovf  (memrd && sel_stat),
        .dout     (fifo_dout),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .overflow (fifo_ovf)
    );

    assign kbd_irq = !fifo_empty;

    logic [15:0] coll_rd;

`ifdef SPRITE_COLLISION_EN
    logic [N_SPRITES-1:0] coll_q;
    logic [N_SPRITES-1:0] coll_set;

    always_comb begin
        coll_set = '0;
        for (int j = 1; j < N_SPRITES; j++) begin
            if (shadow[0].ctrl[CTRL_EN] && shadow[j].ctrl[CTRL_EN] &&
                span_overlap({1'b0, shadow[0].x[9:0]},
                             {1'b0, shadow[j].x[9:0]}, 11'(BMP_W)) &&
                span_overlap({1'b0, shadow[0].y[9:0]},
                             {1'b0, shadow[j].y[9:0]}, 11'(BMP_H)))
                coll_set[j] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            coll_q <= '0;
        else
            coll_q <= ((memrd && sel_coll) ? '0 : coll_q) |
                      (commit ? coll_set : '0);
    end

    assign coll_rd = 16'(coll_q);
`else
    assign coll_rd = 16'h0000;
`endif

    logic [15:0] spr_rd;

    always_comb begin
        spr_rd = '0;
        for (int i = 0; i < N_SPRITES; i++) begin
            if (idx == IDX_W'(i)) begin
                if (off < 5'(BMP_H))
                    spr_rd = shadow[i].rows[off[3:0]];
                else if (off == 5'(OFF_X))
                    spr_rd = shadow[i].x;
                else if (off == 5'(OFF_Y))
                    spr_rd = shadow[i].y;
                else if (off == 5'(OFF_CTRL))
                    spr_rd = shadow[i].ctrl;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        unique case (1'b1)
            spr_hit:  rd_data = spr_rd;
            sel_data: rd_data = fifo_empty ? 16'h0000 : {8'h00, fifo_dout};
            sel_stat: rd_data = {14'b0, fifo_ovf, !fifo_empty};
            sel_coll: rd_data = coll_rd;
            default:  rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_sprite_regfile.sv
// Directed self-checking bench for sprite_regfile (default parameters).
module tb_sprite_regfile;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [11:0]   address;
    logic [15:0]   wr_data;
    logic          memwt;
    logic          memrd;
    logic [15:0]   rd_data;
    logic          hit;
    logic          ackx;
    logic          vsync_irq;
    logic          kbd_valid;
    logic [7:0]    kbd_code;
    logic          kbd_irq;
    logic [511:0]  sprite_bitmap;
    logic [19:0]   sprite_x;
    logic [19:0]   sprite_y;
    logic [1:0]    sprite_en;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [11:0] A_KDATA = 12'h200;
    localparam logic [11:0] A_KSTAT = 12'h201;
    localparam logic [11:0] A_COLL  = 12'h202;

    always #5 clk = ~clk;

    sprite_regfile dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .address       (address),
        .wr_data       (wr_data),
        .memwt         (memwt),
        .memrd         (memrd),
        .rd_data       (rd_data),
        .hit           (hit),
        .ackx          (ackx),
        .vsync_irq     (vsync_irq),
        .kbd_valid     (kbd_valid),
        .kbd_code      (kbd_code),
        .kbd_irq       (kbd_irq),
        .sprite_bitmap (sprite_bitmap),
        .sprite_x      (sprite_x),
        .sprite_y      (sprite_y),
        .sprite_en     (sprite_en)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [15:0] d);
        address = a;
        wr_data = d;
        memwt   = 1'b1;
        tick();
        memwt   = 1'b0;
        address = '0;
    endtask

    task automatic vsync_pulse();
        vsync_irq = 1'b1;
        tick();
        vsync_irq = 1'b0;
        tick();
    endtask

    task automatic push(input logic [7:0] c);
        kbd_valid = 1'b1;
        kbd_code  = c;
        tick();
        kbd_valid = 1'b0;
    endtask

    task automatic peek(input logic [11:0] a);
        address = a;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if (sprite_x !== '0 || sprite_y !== '0 || sprite_en !== '0 || sprite_bitmap !== '0 || kbd_irq !== 1'b0)
            $display("FAIL reset_outputs got x=%h y=%h en=%b irq=%b want 0", sprite_x, sprite_y, sprite_en, kbd_irq);
        else n_pass++;
        rst_n = 1'b1;
        tick();
        peek(12'h1C0);
        n_checks++;
        if (rd_data !== 16'h0000 || hit !== 1'b1)
            $display("FAIL reset_row0 got rd=%h hit=%b want 0000/1", rd_data, hit);
        else n_pass++;
        peek(12'h1BF);
        n_checks++;
        if (rd_data !== 16'h0000 || hit !== 1'b0)
            $display("FAIL below_base got rd=%h hit=%b want 0000/0", rd_data, hit);
        else n_pass++;
        peek(12'h203);
        n_checks++;
        if (hit !== 1'b0 || ackx !== 1'b0)
            $display("FAIL past_coll got hit=%b ackx=%b want 0/0", hit, ackx);
        else n_pass++;
        peek(A_KDATA);
        n_checks++;
        if (hit !== 1'b1 || ackx !== 1'b1)
            $display("FAIL kdata_decode got hit=%b ackx=%b want 1/1", hit, ackx);
        else n_pass++;
    endtask

    task automatic test_commit();
        wr(12'h1F0, 16'h0064);
        n_checks++;
        if (sprite_x[19:10] !== 10'd0)
            $display("FAIL x_pre_commit got %0d want 0", sprite_x[19:10]);
        else n_pass++;
        peek(12'h1F0);
        n_checks++;
        if (rd_data !== 16'h0064)
            $display("FAIL x_shadow_rd got %h want 0064", rd_data);
        else n_pass++;
        vsync_irq = 1'b1;
        tick();
        n_checks++;
        if (sprite_x[19:10] !== 10'd100)
            $display("FAIL x_post_commit got %0d want 100", sprite_x[19:10]);
        else n_pass++;
        vsync_irq = 1'b0;
        tick();
        wr(12'h1F1, 16'hFC05);
        wr(12'h1F2, 16'h0001);
        wr(12'h1D3, 16'hBEEF);
        wr(12'h1E0, 16'h1234);
        peek(12'h1D3);
        n_checks++;
        if (rd_data !== 16'h0000 || hit !== 1'b1)
            $display("FAIL unused_off got rd=%h hit=%b want 0000/1", rd_data, hit);
        else n_pass++;
        peek(12'h1F1);
        n_checks++;
        if (rd_data !== 16'hFC05)
            $display("FAIL y_full_rd got %h want fc05", rd_data);
        else n_pass++;
        vsync_pulse();
        n_checks++;
        if (sprite_y[19:10] !== 10'h005 || sprite_en !== 2'b10 || sprite_bitmap[256 +: 16] !== 16'h1234)
            $display("FAIL commit2 got y=%h en=%b row=%h want 005/10/1234", sprite_y[19:10], sprite_en, sprite_bitmap[256 +: 16]);
        else n_pass++;
    endtask

    task automatic test_same_cycle();
        address   = 12'h1C3;
        wr_data   = 16'hFFFF;
        memwt     = 1'b1;
        vsync_irq = 1'b1;
        tick();
        memwt = 1'b0;
        n_checks++;
        if (sprite_bitmap[48 +: 16] !== 16'h0000)
            $display("FAIL row3_same_edge got %h want 0000", sprite_bitmap[48 +: 16]);
        else n_pass++;
        peek(12'h1C3);
        n_checks++;
        if (rd_data !== 16'hFFFF)
            $display("FAIL row3_shadow got %h want ffff", rd_data);
        else n_pass++;
        vsync_irq = 1'b0;
        tick();
        vsync_pulse();
        n_checks++;
        if (sprite_bitmap[48 +: 16] !== 16'hFFFF)
            $display("FAIL row3_next_frame got %h want ffff", sprite_bitmap[48 +: 16]);
        else n_pass++;
    endtask

    task automatic test_fifo();
        logic [7:0] codes [3];
        codes[0] = 8'h1C;
        codes[1] = 8'h32;
        codes[2] = 8'h21;
        for (int i = 0; i < 3; i++) push(codes[i]);
        n_checks++;
        if (kbd_irq !== 1'b1)
            $display("FAIL irq_after_push got %b want 1", kbd_irq);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            address = A_KDATA;
            memrd   = 1'b1;
            #1;
            n_checks++;
            if (rd_data !== ((i < 3) ? {8'h00, codes[i < 3 ? i : 0]} : 16'h0000))
                $display("FAIL pop%0d got %h want %h", i, rd_data, (i < 3) ? {8'h00, codes[i < 3 ? i : 0]} : 16'h0000);
            else n_pass++;
            tick();
            memrd = 1'b0;
        end
        n_checks++;
        if (kbd_irq !== 1'b0)
            $display("FAIL irq_drained got %b want 0", kbd_irq);
        else n_pass++;
        address   = A_KDATA;
        memrd     = 1'b1;
        kbd_valid = 1'b1;
        kbd_code  = 8'h55;
        tick();
        memrd     = 1'b0;
        kbd_valid = 1'b0;
        n_checks++;
        if (kbd_irq !== 1'b1 || rd_data !== 16'h0055)
            $display("FAIL push_pop_empty got irq=%b rd=%h want 1/0055", kbd_irq, rd_data);
        else n_pass++;
        address   = A_KDATA;
        memrd     = 1'b1;
        kbd_valid = 1'b1;
        kbd_code  = 8'h66;
        tick();
        kbd_valid = 1'b0;
        #1;
        n_checks++;
        if (rd_data !== 16'h0066)
            $display("FAIL push_pop_busy got %h want 0066", rd_data);
        else n_pass++;
        tick();
        memrd = 1'b0;
        n_checks++;
        if (kbd_irq !== 1'b0)
            $display("FAIL push_pop_count got irq=%b want 0", kbd_irq);
        else n_pass++;
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 5; i++) push(8'(i));
        peek(A_KSTAT);
        n_checks++;
        if (rd_data !== 16'h0003)
            $display("FAIL status_ovf got %h want 0003", rd_data);
        else n_pass++;
        memrd = 1'b1;
        tick();
        memrd = 1'b0;
        #1;
        n_checks++;
        if (rd_data !== 16'h0001)
            $display("FAIL status_clr got %h want 0001", rd_data);
        else n_pass++;
        for (int i = 1; i <= 5; i++) begin
            address = A_KDATA;
            memrd   = 1'b1;
            #1;
            n_checks++;
            if (rd_data !== ((i <= 4) ? 16'(i) : 16'h0000))
                $display("FAIL ovf_pop%0d got %h want %h", i, rd_data, (i <= 4) ? 16'(i) : 16'h0000);
            else n_pass++;
            tick();
            memrd = 1'b0;
        end
    endtask

    task automatic test_collision();
`ifdef SPRITE_COLLISION_EN
        wr(12'h1D0, 16'd320);
        wr(12'h1D1, 16'd240);
        wr(12'h1D2, 16'h0001);
        wr(12'h1F0, 16'd325);
        wr(12'h1F1, 16'd234);
        wr(12'h1F2, 16'h0001);
        vsync_pulse();
        peek(A_COLL);
        n_checks++;
        if (rd_data !== 16'h0002)
            $display("FAIL collide_set got %h want 0002", rd_data);
        else n_pass++;
        memrd = 1'b1;
        tick();
        memrd = 1'b0;
        #1;
        n_checks++;
        if (rd_data !== 16'h0000)
            $display("FAIL collide_clr got %h want 0000", rd_data);
        else n_pass++;
        wr(12'h1F0, 16'd400);
        vsync_pulse();
        peek(A_COLL);
        n_checks++;
        if (rd_data !== 16'h0000)
            $display("FAIL collide_apart got %h want 0000", rd_data);
        else n_pass++;
`else
        wr(12'h1D0, 16'd320);
        wr(12'h1D2, 16'h0001);
        vsync_pulse();
        peek(A_COLL);
        n_checks++;
        if (rd_data !== 16'h0000 || hit !== 1'b1)
            $display("FAIL collide_off got rd=%h hit=%b want 0000/1", rd_data, hit);
        else n_pass++;
        n_checks++;
        if (sprite_x[9:0] !== 10'd320 || sprite_en !== 2'b11)
            $display("FAIL s0_commit got x=%0d en=%b want 320/11", sprite_x[9:0], sprite_en);
        else n_pass++;
`endif
    endtask

    task automatic test_reset_mid();
        push(8'hAA);
        push(8'hBB);
        wr(12'h1C0, 16'h1234);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (sprite_x !== '0 || sprite_y !== '0 || sprite_en !== '0 || sprite_bitmap !== '0 || kbd_irq !== 1'b0)
            $display("FAIL midreset_out got x=%h en=%b irq=%b want 0", sprite_x, sprite_en, kbd_irq);
        else n_pass++;
        tick();
        rst_n = 1'b1;
        tick();
        peek(12'h1C0);
        n_checks++;
        if (rd_data !== 16'h0000)
            $display("FAIL midreset_shadow got %h want 0000", rd_data);
        else n_pass++;
        peek(A_KDATA);
        n_checks++;
        if (rd_data !== 16'h0000)
            $display("FAIL midreset_fifo got %h want 0000", rd_data);
        else n_pass++;
        vsync_pulse();
        n_checks++;
        if (sprite_x !== '0 || sprite_y !== '0 || sprite_en !== '0 || sprite_bitmap !== '0)
            $display("FAIL midreset_commit got x=%h y=%h en=%b want 0", sprite_x, sprite_y, sprite_en);
        else n_pass++;
    endtask

    initial begin
        rst_n     = 1'b0;
        address   = '0;
        wr_data   = '0;
        memwt     = 1'b0;
        memrd     = 1'b0;
        vsync_irq = 1'b0;
        kbd_valid = 1'b0;
        kbd_code  = '0;
        test_reset();
        test_commit();
        test_same_cycle();
        test_fifo();
        test_overflow();
        test_collision();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
